// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage indices, FSM encoding and the "no forwarding" select value.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_REDIR    = 2'd2
  } hz_state_e;

  localparam int STG_FI  = 0;
  localparam int STG_DS  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  // Forwarding select meaning "read the register file".
  localparam int HZ_FWD_REGFILE = 0;

  // Redirect down-counter width, enough for REDIRECT_CYC up to 7.
  localparam int REDIR_CW = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Shifting scoreboard of in-flight destinations (entry 1 = MEM .. SBW = WB)
// with youngest-first source-operand match logic.
module pipeline_hazard_ctrl_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int SBW    = 2,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold_mem,
  input  logic              i_ins_v,
  input  logic [AWIDTH-1:0] i_ins_rd,
  input  logic              i_ins_load,
  input  logic [AWIDTH-1:0] i_rs1,
  input  logic              i_use_rs1,
  input  logic [AWIDTH-1:0] i_rs2,
  input  logic              i_use_rs2,
  output logic              o_rs1_hit,
  output logic [FW-1:0]     o_rs1_idx,
  output logic              o_rs1_load,
  output logic              o_rs2_hit,
  output logic [FW-1:0]     o_rs2_idx,
  output logic              o_rs2_load
);

  logic [SBW:1]      r_v;
  logic [SBW:1]      r_load;
  logic [AWIDTH-1:0] r_rd [1:SBW];

  // While MEM waits, entry 1 holds and a bubble enters the stage behind it,
  // so entry 2 becomes invalid while older entries keep draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every entry
      // samples its neighbour's pre-edge value and the shift stays ordered.
      if (!i_hold_mem) r_v[1] <= i_ins_v;
      r_v[2] <= r_v[1] & ~i_hold_mem;
      for (int k = 3; k <= SBW; k++) r_v[k] <= r_v[k-1];
    end
  end

  // NOTE: only the valid bits need a reset; rd/load are qualified by them,
  // so this payload array is left unreset like a small memory.
  always_ff @(posedge clk) begin
    if (!i_hold_mem) begin
      r_rd[1]   <= i_ins_rd;
      r_load[1] <= i_ins_load;
    end
    for (int k = 2; k <= SBW; k++) begin
      r_rd[k]   <= r_rd[k-1];
      r_load[k] <= r_load[k-1];
    end
  end

  // Scan oldest to youngest so the lowest matching index overrides.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a
    // no-match path would hold the old value and infer a latch.
    o_rs1_hit  = 1'b0;
    o_rs1_idx  = FW'(HZ_FWD_REGFILE);
    o_rs1_load = 1'b0;
    o_rs2_hit  = 1'b0;
    o_rs2_idx  = FW'(HZ_FWD_REGFILE);
    o_rs2_load = 1'b0;
    for (int k = SBW; k >= 1; k--) begin
      if (r_v[k] && (r_rd[k] != '0)) begin
        if (i_use_rs1 && (r_rd[k] == i_rs1)) begin
          o_rs1_hit  = 1'b1;
          o_rs1_idx  = FW'(k);
          o_rs1_load = r_load[k];
        end
        if (i_use_rs2 && (r_rd[k] == i_rs2)) begin
          o_rs2_hit  = 1'b1;
          o_rs2_idx  = FW'(k);
          o_rs2_load = r_load[k];
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: FSM (run / memory wait / redirect), stall/flush
// generation and forwarding selects. Build option: FORWARDING_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter  int AWIDTH       = 5,
  parameter  int NUM_STAGES   = 5,
  parameter  int REDIRECT_CYC = 2,
  localparam int SBW          = NUM_STAGES - 3,
  localparam int FW           = $clog2(SBW + 1)
) (
  input  logic                  hz_clk,
  input  logic                  hz_rst,
  input  logic                  hz_i_valid,
  input  logic [AWIDTH-1:0]     hz_i_rs1,
  input  logic [AWIDTH-1:0]     hz_i_rs2,
  input  logic                  hz_i_use_rs1,
  input  logic                  hz_i_use_rs2,
  input  logic [AWIDTH-1:0]     hz_i_rd,
  input  logic                  hz_i_we,
  input  logic                  hz_i_is_load,
  input  logic                  hz_i_change_pc,
  input  logic                  hz_i_ex_busy,
  input  logic                  hz_i_me_req,
  input  logic                  hz_i_me_ack,
  output logic [NUM_STAGES-1:0] hz_o_stall,
  output logic [NUM_STAGES-1:0] hz_o_flush,
  output logic [FW-1:0]         hz_o_fwd_rs1,
  output logic [FW-1:0]         hz_o_fwd_rs2
);

  localparam logic [REDIR_CW-1:0] REDIR_LOAD = REDIR_CW'(REDIRECT_CYC - 1);

  hz_state_e             r_state, w_state_nxt;
  logic [REDIR_CW-1:0]   r_redir_cnt, w_redir_cnt_nxt;
  logic                  r_pend_redir, w_pend_nxt;
  logic                  w_mem_hold, w_redir_req;
  logic                  w_mem_stall, w_redir_flush;
  logic                  w_data_haz;
  logic [NUM_STAGES-1:0] w_stall, w_flush;
  logic                  w_ins_v;
  logic                  w_rs1_hit, w_rs1_load, w_rs2_hit, w_rs2_load;
  logic [FW-1:0]         w_rs1_idx, w_rs2_idx;

  assign w_ins_v = hz_i_valid && hz_i_we && !w_stall[STG_EX] && !w_flush[STG_EX];

  pipeline_hazard_ctrl_scoreboard #(
    .AWIDTH (AWIDTH),
    .SBW    (SBW),
    .FW     (FW)
  ) u_scoreboard (
    .clk        (hz_clk),
    .rst_n      (hz_rst),
    .i_hold_mem (w_stall[STG_MEM]),
    .i_ins_v    (w_ins_v),
    .i_ins_rd   (hz_i_rd),
    .i_ins_load (hz_i_is_load),
    .i_rs1      (hz_i_rs1),
    .i_use_rs1  (hz_i_use_rs1),
    .i_rs2      (hz_i_rs2),
    .i_use_rs2  (hz_i_use_rs2),
    .o_rs1_hit  (w_rs1_hit),
    .o_rs1_idx  (w_rs1_idx),
    .o_rs1_load (w_rs1_load),
    .o_rs2_hit  (w_rs2_hit),
    .o_rs2_idx  (w_rs2_idx),
    .o_rs2_load (w_rs2_load)
  );

  always_ff @(posedge hz_clk or negedge hz_rst) begin
    if (!hz_rst) begin
      r_state      <= S_RUN;
      r_redir_cnt  <= '0;
      r_pend_redir <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_redir_cnt  <= w_redir_cnt_nxt;
      r_pend_redir <= w_pend_nxt;
    end
  end

  // A pending redirect, or one interrupted by a memory wait, is replayed on
  // the cycle the memory acknowledges.
  assign w_mem_hold  = hz_i_me_req && !hz_i_me_ack;
  assign w_redir_req = hz_i_change_pc || r_pend_redir;

  always_comb begin
    w_state_nxt     = r_state;
    w_redir_cnt_nxt = r_redir_cnt;
    w_pend_nxt      = r_pend_redir;
    w_mem_stall     = 1'b0;
    w_redir_flush   = 1'b0;
    if (w_mem_hold) begin
      w_state_nxt     = S_MEM_WAIT;
      w_mem_stall     = 1'b1;
      w_redir_cnt_nxt = '0;
      w_pend_nxt      = w_redir_req || (r_state == S_REDIR);
    end else begin
      w_pend_nxt = 1'b0;
      if (w_redir_req) begin
        w_redir_flush   = 1'b1;
        w_redir_cnt_nxt = REDIR_LOAD;
        w_state_nxt     = (REDIRECT_CYC > 1) ? S_REDIR : S_RUN;
      end else if (r_state == S_REDIR) begin
        w_redir_flush = 1'b1;
        if (r_redir_cnt <= REDIR_CW'(1)) begin
          w_state_nxt     = S_RUN;
          w_redir_cnt_nxt = '0;
        end else begin
          w_redir_cnt_nxt = r_redir_cnt - REDIR_CW'(1);
        end
      end else begin
        w_state_nxt = S_RUN;
      end
    end
  end

`ifdef FORWARDING_EN
  // Only a load still in MEM cannot be forwarded.
  assign w_data_haz = hz_i_valid &&
                      ((w_rs1_hit && w_rs1_load && (w_rs1_idx == FW'(1))) ||
                       (w_rs2_hit && w_rs2_load && (w_rs2_idx == FW'(1))));
`else
  assign w_data_haz = hz_i_valid && (w_rs1_hit || w_rs2_hit);
`endif

  always_comb begin
    w_stall = '0;
    w_flush = '0;
    if (!hz_rst) begin
      w_flush = '1;
    end else if (w_mem_stall) begin
      w_stall[STG_MEM:STG_FI] = '1;
      w_flush[STG_MEM+1]      = 1'b1;
    end else begin
      if (hz_i_ex_busy || w_data_haz) begin
        w_stall[STG_EX:STG_FI] = '1;
        w_flush[STG_MEM]       = 1'b1;
      end
      if (w_redir_flush) w_flush[STG_DS:STG_FI] = '1;
      w_stall = w_stall & ~w_flush;
    end
  end

  assign hz_o_stall = w_stall;
  assign hz_o_flush = w_flush;

`ifdef FORWARDING_EN
  logic w_fwd_ok;
  assign w_fwd_ok     = hz_rst && hz_i_valid && !(|w_stall);
  assign hz_o_fwd_rs1 = (w_fwd_ok && w_rs1_hit) ? w_rs1_idx : FW'(HZ_FWD_REGFILE);
  assign hz_o_fwd_rs2 = (w_fwd_ok && w_rs2_hit) ? w_rs2_idx : FW'(HZ_FWD_REGFILE);
`else
  // Without forwarding every match stalls, so the selects carry no information.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_rs1_idx, w_rs2_idx, w_rs1_load, w_rs2_load};
  assign hz_o_fwd_rs1 = FW'(HZ_FWD_REGFILE);
  assign hz_o_fwd_rs2 = FW'(HZ_FWD_REGFILE);
`endif

endmodule
